// File: rtl/datapath_mem_writeback.sv
// Writes the datapath's no-backpressure output stream to consecutive memory addresses.
// A show-ahead skid FIFO absorbs memory stalls; words arriving on a full FIFO are dropped and flagged.
module datapath_mem_writeback #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_STEP  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_words,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [15:0]       words_written
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [15:0]         num_q, num_d;
  logic [15:0]         accept_q, accept_d;
  logic [15:0]         ww_q, ww_d;
  logic                ovf_q, ovf_d;
  logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

  logic fifo_empty, fifo_full, req_vld, pop, capture, push, drop, start_acc;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign req_vld    = (state_q == S_RUN) && !fifo_empty;
  assign pop        = req_vld && mem_req_ready;
  assign capture    = (state_q == S_RUN) && in_valid && (accept_q < num_q);
  assign push       = capture && (!fifo_full || pop);
  assign drop       = capture && fifo_full && !pop;
  assign start_acc  = (state_q == S_IDLE) && start;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      num_q    <= '0;
      accept_q <= '0;
      ww_q     <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      num_q    <= num_d;
      accept_q <= accept_d;
      ww_q     <= ww_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= in_data;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if ((accept_q == num_q) && fifo_empty && !req_vld) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Dropped words still count as accepted so the job always terminates.
  always_comb begin
    base_d   = base_q;
    num_d    = num_q;
    accept_d = accept_q;
    ww_d     = ww_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (start_acc) begin
      base_d   = base_addr;
      num_d    = num_words;
      accept_d = '0;
      ww_d     = '0;
      ovf_d    = 1'b0;
    end
    if (capture) accept_d = accept_q + 16'd1;
    if (push)    wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (drop)    ovf_d    = 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      ww_d     = ww_q + 16'd1;
    end
  end

  always_comb begin
    mem_req_valid = req_vld;
    mem_req_data  = req_vld ? mem_q[rd_ptr_q[PTR_W-1:0]] : '0;
    mem_req_addr  = base_q + ADDR_W'(ww_q) * ADDR_W'(ADDR_STEP);
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    overflow      = ovf_q;
    words_written = ww_q;
  end

endmodule

// File: tb/tb_datapath_mem_writeback.sv
// Directed bench for datapath_mem_writeback: scoreboard of expected (addr,data) writes,
// popped and compared as the memory port transfers.
`define CHK(tag, obs, exp) begin \
  checks++; \
  assert ((obs) === (exp)) else begin \
    errors++; \
    $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
  end \
end

module tb_datapath_mem_writeback;
  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] num_words;
  logic        in_valid;
  logic [63:0] in_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [63:0] mem_req_data;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] words_written;

  int checks = 0;
  int errors = 0;
  int writes = 0;
  int dones  = 0;
  int dones0 = 0;
  int writes0 = 0;
  logic [15:0] ww_at_done = '0;
  logic [95:0] sb_q [$];
  logic [95:0] exp_req;
  logic [31:0] exp_addr;
  logic        stall_q = 1'b0;
  logic [95:0] stall_req = '0;

  always #5 clock = ~clock;

  datapath_mem_writeback dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .num_words(num_words), .in_valid(in_valid), .in_data(in_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .busy(busy),
    .done(done), .overflow(overflow), .words_written(words_written)
  );

  // Memory-side monitor: scoreboard compare on transfer, hold-stability while stalled.
  always @(negedge clock) begin
    if (reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) `CHK("hold", {mem_req_valid, mem_req_addr, mem_req_data}, {1'b1, stall_req})
      if (done) begin
        dones++;
        ww_at_done = words_written;
      end
      if (mem_req_valid && mem_req_ready) begin
        writes++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_write observed=%0h expected=none", {mem_req_addr, mem_req_data});
        end else begin
          exp_req = sb_q.pop_front();
          `CHK("write", {mem_req_addr, mem_req_data}, exp_req)
        end
      end
      stall_q   = mem_req_valid && !mem_req_ready;
      stall_req = {mem_req_addr, mem_req_data};
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_job(input logic [31:0] b, input logic [15:0] n);
    base_addr = b;
    num_words = n;
    exp_addr  = b;
    dones0    = dones;
    writes0   = writes;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic send(input logic [63:0] d, input bit expect_wr);
    in_valid = 1'b1;
    in_data  = d;
    if (expect_wr) begin
      sb_q.push_back({exp_addr, d});
      exp_addr = exp_addr + 32'd8;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (dones == dones0 && i < budget) begin
      tick();
      i++;
    end
    `CHK("done_seen", dones, dones0 + 1)
    repeat (3) tick();
    @(negedge clock);
    `CHK("done_once", dones, dones0 + 1)
    `CHK("idle_after", busy, 1'b0)
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clock);
    `CHK(tag, {mem_req_valid, busy, done, overflow, mem_req_addr, mem_req_data, words_written},
         {4'b0000, 32'h0, 64'h0, 16'h0})
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
    in_valid = 1'b0; in_data = '0; mem_req_ready = 1'b0; exp_addr = '0;
    repeat (3) tick();
    check_reset_state("reset_vals");
    tick();
    reset = 1'b0;
    tick();

    // T1: four back-to-back words, memory always ready
    mem_req_ready = 1'b1;
    start_job(32'h0000_1000, 16'd4);
    send(64'hAAAA_0000_0000_000A, 1'b1);
    send(64'hBBBB_0000_0000_000B, 1'b1);
    send(64'hCCCC_0000_0000_000C, 1'b1);
    send(64'hDDDD_0000_0000_000D, 1'b1);
    wait_done(20);
    `CHK("t1_ww", ww_at_done, 16'd4)
    `CHK("t1_ovf", overflow, 1'b0)
    `CHK("t1_writes", writes - writes0, 4)
    `CHK("t1_sb_empty", sb_q.size(), 0)

    // T2: memory stalled while a full FIFO's worth arrives
    mem_req_ready = 1'b0;
    start_job(32'h0000_1000, 16'd8);
    for (int i = 0; i < 8; i++) send(64'h2000_0000_0000_0000 + 64'(i), 1'b1);
    repeat (12) tick();
    @(negedge clock);
    `CHK("t2_stall_req", {mem_req_valid, mem_req_addr, mem_req_data},
         {1'b1, 32'h0000_1000, 64'h2000_0000_0000_0000})
    `CHK("t2_no_writes", writes - writes0, 0)
    tick();
    mem_req_ready = 1'b1;
    wait_done(40);
    `CHK("t2_ww", ww_at_done, 16'd8)
    `CHK("t2_writes", writes - writes0, 8)

    // T3: overrun while stalled; words 9..12 are dropped
    mem_req_ready = 1'b0;
    start_job(32'h0000_2000, 16'd12);
    for (int i = 0; i < 12; i++) send(64'h3000_0000_0000_0000 + 64'(i), i < 8);
    @(negedge clock);
    `CHK("t3_ovf_set", overflow, 1'b1)
    `CHK("t3_no_writes", writes - writes0, 0)
    tick();
    mem_req_ready = 1'b1;
    wait_done(40);
    `CHK("t3_ww", ww_at_done, 16'd8)
    `CHK("t3_ovf_sticky", overflow, 1'b1)
    `CHK("t3_writes", writes - writes0, 8)

    // T4: zero-length job, then stray input while idle
    start_job(32'h0000_5000, 16'd0);
    @(negedge clock);
    `CHK("t4_run", {busy, done, overflow}, 3'b100)
    tick();
    @(negedge clock);
    `CHK("t4_done", {busy, done, words_written}, {2'b11, 16'd0})
    tick();
    @(negedge clock);
    `CHK("t4_idle", {busy, done}, 2'b00)
    in_valid = 1'b1;
    in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (3) tick();
    in_valid = 1'b0;
    @(negedge clock);
    `CHK("t4_stray", {busy, mem_req_valid}, 2'b00)
    `CHK("t4_no_writes", writes - writes0, 0)

    // T5: address wraps past 2^32
    start_job(32'hFFFF_FFF8, 16'd2);
    send(64'h5555_0000_0000_0001, 1'b1);
    send(64'h5555_0000_0000_0002, 1'b1);
    wait_done(20);
    `CHK("t5_ww", ww_at_done, 16'd2)

    // T6: reset mid-job after three writes, then a clean job
    start_job(32'h0000_3000, 16'd6);
    for (int i = 0; i < 3; i++) send(64'h6000_0000_0000_0000 + 64'(i), 1'b1);
    for (int i = 0; i < 20 && (writes - writes0) < 3; i++) tick();
    `CHK("t6_three_writes", writes - writes0, 3)
    tick();
    reset = 1'b1;
    tick();
    check_reset_state("t6_reset_vals");
    `CHK("t6_no_done", dones, dones0)
    `CHK("t6_sb_empty", sb_q.size(), 0)
    reset = 1'b0;
    tick();
    start_job(32'h0000_4000, 16'd2);
    send(64'h7777_0000_0000_0001, 1'b1);
    send(64'h7777_0000_0000_0002, 1'b1);
    wait_done(20);
    `CHK("t6_ww", ww_at_done, 16'd2)
    `CHK("t6_ovf", overflow, 1'b0)
    `CHK("final_sb_empty", sb_q.size(), 0)

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
